// File: rtl/data_sram_slave.sv
// data_sram_slave: responder for the CPU data SRAM-like bus.
// Backs a word-addressed RAM plus a small MMIO window (LED register,
// synchronized switches, free-running timer). One access per cycle, read
// data returned exactly one cycle after the request, read-before-write.
//
// Ports:
//   clk          system clock, all state on rising edge
//   rst          synchronous active-high reset
//   sram_en      access request this cycle
//   sram_wen     byte-lane write enables (0 = read)
//   sram_addr    physical byte address, bits [1:0] ignored
//   sram_wdata   lane-aligned write data
//   sram_rdata   read data, valid the cycle after the request
//   switch_in    asynchronous board switches
//   led_out      LED register contents
module data_sram_slave #(
  parameter int          ADDR_W    = 12,
  parameter logic [15:0] MMIO_HI   = 16'h1faf,
  parameter logic [15:0] LED_OFF   = 16'hf000,
  parameter logic [15:0] SW_OFF    = 16'hf010,
  parameter logic [15:0] TIMER_OFF = 16'he000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sram_en,
  input  logic [3:0]  sram_wen,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  input  logic [15:0] switch_in,
  output logic [15:0] led_out
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]       mem [DEPTH];
  logic [31:0]       ram_dout_q;

  logic              mmio_hit;
  logic [15:0]       offset;
  logic [ADDR_W-1:0] word_idx;

  logic [15:0]       led_q, led_d;
  logic [31:0]       timer_q, timer_d;
  logic [15:0]       sw_meta_q, sw_sync_q;
  logic [31:0]       mmio_dout_q, mmio_dout_d;
  logic              sel_mmio_q;
  // Forces sram_rdata to 0 from reset until the first accepted request,
  // since the RAM output register itself is not reset.
  logic              zero_q;

  assign mmio_hit = (sram_addr[31:16] == MMIO_HI);
  assign offset   = sram_addr[15:0];
  assign word_idx = sram_addr[ADDR_W+1:2];

  // Block RAM with per-byte write enables; the read port sees the old word.
  always_ff @(posedge clk) begin
    if (sram_en) begin
      for (int i = 0; i < 4; i++) begin
        if (!rst && !mmio_hit && sram_wen[i]) begin
          mem[word_idx][8*i +: 8] <= sram_wdata[8*i +: 8];
        end
      end
      ram_dout_q <= mem[word_idx];
    end
  end

  always_comb begin
    led_d       = led_q;
    timer_d     = timer_q + 32'd1;
    mmio_dout_d = 32'h0;

    if (offset == LED_OFF) begin
      mmio_dout_d = {16'h0, led_q};
    end else if (offset == SW_OFF) begin
      mmio_dout_d = {16'h0, sw_sync_q};
    end else if (offset == TIMER_OFF) begin
      mmio_dout_d = timer_q;
    end

    if (sram_en && mmio_hit && (offset == LED_OFF)) begin
      for (int i = 0; i < 2; i++) begin
        if (sram_wen[i]) led_d[8*i +: 8] = sram_wdata[8*i +: 8];
      end
    end

    // A timer write replaces the increment for that cycle.
    if (sram_en && mmio_hit && (offset == TIMER_OFF) && (|sram_wen)) begin
      timer_d = timer_q;
      for (int i = 0; i < 4; i++) begin
        if (sram_wen[i]) timer_d[8*i +: 8] = sram_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q       <= 16'h0;
      timer_q     <= 32'h0;
      sw_meta_q   <= 16'h0;
      sw_sync_q   <= 16'h0;
      mmio_dout_q <= 32'h0;
      sel_mmio_q  <= 1'b0;
      zero_q      <= 1'b1;
    end else begin
      sw_meta_q <= switch_in;
      sw_sync_q <= sw_meta_q;
      led_q     <= led_d;
      timer_q   <= timer_d;
      if (sram_en) begin
        sel_mmio_q  <= mmio_hit;
        mmio_dout_q <= mmio_dout_d;
        zero_q      <= 1'b0;
      end
    end
  end

  assign sram_rdata = zero_q     ? 32'h0 :
                      sel_mmio_q ? mmio_dout_q : ram_dout_q;
  assign led_out    = led_q;

endmodule

// File: tb/tb_data_sram_slave.sv
module tb_data_sram_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic [15:0] switch_in;
  logic [15:0] led_out;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] LED_A   = 32'h1faff000;
  localparam logic [31:0] SW_A    = 32'h1faff010;
  localparam logic [31:0] TIMER_A = 32'h1fafe000;

  data_sram_slave dut (
    .clk        (clk),
    .rst        (rst),
    .sram_en    (sram_en),
    .sram_wen   (sram_wen),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .switch_in  (switch_in),
    .led_out    (led_out)
  );

  always #5 clk = ~clk;

  // Present one request, clock it, and sample 1 time unit after the edge.
  task automatic cyc(input logic r, input logic en, input logic [3:0] wen,
                     input logic [31:0] addr, input logic [31:0] wdata);
    rst        = r;
    sram_en    = en;
    sram_wen   = wen;
    sram_addr  = addr;
    sram_wdata = wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; sram_en = 1'b0; sram_wen = 4'h0;
    sram_addr = 32'h0; sram_wdata = 32'h0; switch_in = 16'h0;
    #2;

    // Reset
    cyc(1, 0, 4'h0, 32'h0, 32'h0);
    cyc(1, 1, 4'h0, 32'h10, 32'h0);
    check("reset_rdata", sram_rdata, 32'h0);
    check("reset_led", {16'h0, led_out}, 32'h0);
    cyc(0, 0, 4'h0, 32'h0, 32'h0);
    check("idle_after_reset_rdata", sram_rdata, 32'h0);

    // Byte-lane writes and read-before-write
    cyc(0, 1, 4'b1111, 32'h100, 32'h11223344);
    cyc(0, 1, 4'b0100, 32'h100, 32'hAABBCCDD);
    check("rbw_lane_write", sram_rdata, 32'h11223344);
    cyc(0, 1, 4'b0000, 32'h100, 32'h0);
    check("byte_lane_merge", sram_rdata, 32'h11BB3344);
    cyc(0, 1, 4'b1111, 32'h100, 32'hDEADBEEF);
    check("rbw_full_write", sram_rdata, 32'h11BB3344);
    cyc(0, 1, 4'b0000, 32'h100, 32'h0);
    check("read_after_write", sram_rdata, 32'hDEADBEEF);

    // Aliasing modulo RAM size
    cyc(0, 1, 4'b1111, 32'h4000, 32'h5A5A5A5A);
    cyc(0, 1, 4'b0000, 32'h0, 32'h0);
    check("alias_read", sram_rdata, 32'h5A5A5A5A);
    cyc(0, 0, 4'b1111, 32'h100, 32'h12345678);
    check("hold_when_idle", sram_rdata, 32'h5A5A5A5A);
    cyc(0, 1, 4'b0000, 32'h100, 32'h0);
    check("idle_no_write", sram_rdata, 32'hDEADBEEF);

    // LED register
    cyc(0, 1, 4'b1111, LED_A, 32'hFFFF1234);
    check("led_write", {16'h0, led_out}, 32'h00001234);
    cyc(0, 1, 4'b0000, LED_A, 32'h0);
    check("led_read", sram_rdata, 32'h00001234);
    cyc(0, 1, 4'b0010, LED_A, 32'h0000AB00);
    check("led_lane1", {16'h0, led_out}, 32'h0000AB34);

    // Switch synchronizer
    switch_in = 16'hBEEF;
    cyc(0, 0, 4'h0, 32'h0, 32'h0);
    cyc(0, 0, 4'h0, 32'h0, 32'h0);
    cyc(0, 1, 4'b0000, SW_A, 32'h0);
    check("switch_read", sram_rdata, 32'h0000BEEF);
    switch_in = 16'h1234;
    cyc(0, 1, 4'b1111, SW_A, 32'hFFFFFFFF);
    check("switch_lag0", sram_rdata, 32'h0000BEEF);
    cyc(0, 1, 4'b0000, SW_A, 32'h0);
    check("switch_lag1", sram_rdata, 32'h0000BEEF);
    cyc(0, 1, 4'b0000, SW_A, 32'h0);
    check("switch_lag2", sram_rdata, 32'h00001234);

    // Unmapped MMIO offset must not touch RAM word 1
    cyc(0, 1, 4'b1111, 32'h4, 32'h01020304);
    cyc(0, 1, 4'b1111, 32'h1faf0004, 32'hFFFFFFFF);
    check("unmapped_rbw", sram_rdata, 32'h0);
    cyc(0, 1, 4'b0000, 32'h1faf0004, 32'h0);
    check("unmapped_read", sram_rdata, 32'h0);
    cyc(0, 1, 4'b0000, 32'h4, 32'h0);
    check("unmapped_no_ram", sram_rdata, 32'h01020304);

    // Timer load and wrap
    cyc(0, 1, 4'b1111, TIMER_A, 32'hFFFFFFFE);
    cyc(0, 1, 4'b0000, TIMER_A, 32'h0);
    check("timer_0", sram_rdata, 32'hFFFFFFFE);
    cyc(0, 1, 4'b0000, TIMER_A, 32'h0);
    check("timer_1", sram_rdata, 32'hFFFFFFFF);
    cyc(0, 1, 4'b0000, TIMER_A, 32'h0);
    check("timer_wrap", sram_rdata, 32'h00000000);
    cyc(0, 1, 4'b0001, TIMER_A, 32'h777777AA);
    check("timer_partial_rbw", sram_rdata, 32'h00000001);
    cyc(0, 1, 4'b0000, TIMER_A, 32'h0);
    check("timer_partial", sram_rdata, 32'h000000AA);

    // Reset during writes
    cyc(1, 0, 4'h0, 32'h0, 32'h0);
    check("led_cleared", {16'h0, led_out}, 32'h0);
    cyc(1, 1, 4'b1111, LED_A, 32'h0000FFFF);
    check("rst_led_write", {16'h0, led_out}, 32'h0);
    check("rst_rdata", sram_rdata, 32'h0);
    cyc(1, 1, 4'b1111, 32'h100, 32'h0BADF00D);
    cyc(0, 1, 4'b0000, TIMER_A, 32'h0);
    check("timer_after_reset", sram_rdata, 32'h0);
    check("led_after_reset", {16'h0, led_out}, 32'h0);
    cyc(0, 1, 4'b0000, 32'h100, 32'h0);
    check("rst_ram_write", sram_rdata, 32'hDEADBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
